// File: rtl/loader_fb_sched.sv
// loader_fb_sched: streams one frame of bytes into the CHR back buffer and flips
// buffer_num on the first vblank acknowledge after the last write has completed.
module loader_fb_sched #(
  parameter int unsigned BUF_BYTES = 16384,
  parameter int unsigned ADDR_BITS = 15,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [7:0]           in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [7:0]           mem_wdata_o,
  output logic                 mem_req_o,
  input  logic                 mem_ack_i,
  input  logic                 frame_tick_i,
  output logic                 buffer_num_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 error_o
);

  localparam int unsigned OFF_W = ADDR_BITS - 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WAIT
  } state_t;

  state_t               state_q;
  logic [OFF_W-1:0]     offset_q;
  logic [OFF_W-1:0]     offset_d;
  logic [TMO_W-1:0]     tmo_q;
  logic [TMO_W-1:0]     tmo_d;
  logic                 back_buf_q;
  logic                 abort_pend_q;
  logic                 buffer_num_q;
  logic                 in_ready_q;
  logic                 mem_req_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [7:0]           mem_wdata_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic                 error_q;
  logic                 last_byte;
  logic                 tmo_hit;
  logic                 aborting;

  // Datapath helpers for the handshake/timeout bookkeeping
  always_comb begin
    offset_d  = offset_q + OFF_W'(1);
    tmo_d     = tmo_q + TMO_W'(1);
    last_byte = (offset_q == OFF_W'(BUF_BYTES - 1));
    tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));
    aborting  = abort_pend_q | abort_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      offset_q     <= '0;
      tmo_q        <= '0;
      back_buf_q   <= 1'b0;
      abort_pend_q <= 1'b0;
      buffer_num_q <= 1'b0;
      in_ready_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q      <= S_FILL;
            busy_q       <= 1'b1;
            in_ready_q   <= 1'b1;
            offset_q     <= '0;
            back_buf_q   <= ~buffer_num_q;
            abort_pend_q <= 1'b0;
          end
        end

        S_FILL: begin
          if (start_i) error_q <= 1'b1;
          if (!mem_req_q) begin
            if (abort_i) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b0;
            end else if (in_valid_i && in_ready_q) begin
              mem_req_q   <= 1'b1;
              in_ready_q  <= 1'b0;
              mem_addr_q  <= {back_buf_q, offset_q};
              mem_wdata_q <= in_data_i;
              tmo_q       <= '0;
            end
          end else if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            if (aborting) begin
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
              abort_pend_q <= 1'b0;
            end else if (last_byte) begin
              state_q <= S_WAIT;
            end else begin
              offset_q   <= offset_d;
              in_ready_q <= 1'b1;
            end
          end else if (tmo_hit) begin
            // Memory never answered: give up on the frame without flipping
            mem_req_q    <= 1'b0;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            if (!aborting) error_q <= 1'b1;
          end else begin
            tmo_q <= tmo_d;
            if (abort_i) abort_pend_q <= 1'b1;
          end
        end

        S_WAIT: begin
          if (start_i) error_q <= 1'b1;
          if (abort_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (frame_tick_i) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            buffer_num_q <= ~buffer_num_q;
            frame_done_q <= 1'b1;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b0;
          mem_req_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_req_o    = mem_req_q;
  assign buffer_num_o = buffer_num_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_loader_fb_sched.sv
// Directed bench for loader_fb_sched: cycle table for the handshake basics, then
// full-frame, abort, timeout and reset sequences.
module tb_loader_fb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, in_valid, mem_ack, frame_tick;
  logic [7:0]  in_data;
  logic        in_ready, mem_req, buffer_num, busy, frame_done, error;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;

  int n_checks = 0;
  int n_pass   = 0;
  int frame_bad;

  loader_fb_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_req_o    (mem_req),
    .mem_ack_i    (mem_ack),
    .frame_tick_i (frame_tick),
    .buffer_num_o (buffer_num),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  // ctl = {start, abort, frame_tick, in_valid, mem_ack}; brr = {busy, in_ready, mem_req}
  // efb = {error, frame_done, buffer_num}
  typedef struct {
    logic [4:0]  ctl;
    logic [7:0]  din;
    logic [2:0]  brr;
    logic [14:0] addr;
    logic [7:0]  wd;
    logic [2:0]  efb;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [28:0] observed();
    return {busy, in_ready, mem_req, mem_addr, mem_wdata, error, frame_done, buffer_num};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Offer one byte, wait for acceptance, verify the request it produced
  task automatic push_byte(input int off, input logic bb, input logic tk, input logic st);
    int k;
    k = 0;
    while (!in_ready && k < 16) begin
      step();
      k++;
    end
    if (!in_ready) begin
      frame_bad++;
      if (frame_bad <= 3) $display("in_ready never rose at offset %0d", off);
    end
    in_valid   = 1'b1;
    in_data    = 8'(off);
    frame_tick = tk;
    start      = st;
    step();
    in_valid   = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    if (!mem_req || mem_addr !== {bb, 14'(off)} || mem_wdata !== 8'(off)) begin
      frame_bad++;
      if (frame_bad <= 3)
        $display("bad write at offset %0d: req=%0b addr=0x%0h data=0x%0h", off, mem_req,
                 mem_addr, mem_wdata);
    end
  endtask

  task automatic ack_byte();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    if (mem_req) begin
      frame_bad++;
      if (frame_bad <= 3) $display("mem_req still high after ack");
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    frame_tick = 1'b0; in_data = 8'h00;

    vecs[0] = '{5'b00000, 8'h00, 3'b000, 15'h0000, 8'h00, 3'b000};
    vecs[1] = '{5'b01101, 8'h00, 3'b000, 15'h0000, 8'h00, 3'b000};
    vecs[2] = '{5'b10000, 8'h00, 3'b110, 15'h0000, 8'h00, 3'b000};
    vecs[3] = '{5'b00010, 8'hA5, 3'b101, 15'h4000, 8'hA5, 3'b000};
    vecs[4] = '{5'b00000, 8'h00, 3'b101, 15'h4000, 8'hA5, 3'b000};
    vecs[5] = '{5'b00001, 8'h00, 3'b110, 15'h4000, 8'hA5, 3'b000};
    vecs[6] = '{5'b00010, 8'h3C, 3'b101, 15'h4001, 8'h3C, 3'b000};
    vecs[7] = '{5'b10101, 8'h00, 3'b110, 15'h4001, 8'h3C, 3'b100};
    vecs[8] = '{5'b01010, 8'h77, 3'b000, 15'h4001, 8'h3C, 3'b000};
    vecs[9] = '{5'b00100, 8'h00, 3'b000, 15'h4001, 8'h3C, 3'b000};

    step();
    step();
    chk("reset_state", 32'(observed()), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      {start, abort, frame_tick, in_valid, mem_ack} = vecs[i].ctl;
      in_data = vecs[i].din;
      step();
      chk($sformatf("vec%0d", i), 32'(observed()),
          32'({vecs[i].brr, vecs[i].addr, vecs[i].wd, vecs[i].efb}));
    end
    {start, abort, frame_tick, in_valid, mem_ack} = 5'b0;
    in_data = 8'h00;

    // Abort with a write in flight at offset 300
    frame_bad = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int off = 0; off < 300; off++) begin
      push_byte(off, 1'b1, 1'b0, 1'b0);
      ack_byte();
    end
    push_byte(300, 1'b1, 1'b0, 1'b0);
    chk("abort_prefix_bytes", 32'(frame_bad), 32'd0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_pending", 32'({busy, in_ready, mem_req, error}), 32'b1010);
    chk("abort_addr_held", 32'(mem_addr), 32'h412C);
    step();
    step();
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    chk("abort_done", 32'({busy, in_ready, mem_req, error, buffer_num}), 32'b00000);

    // Frame 1: back buffer 1, stray ticks and a start mid-frame
    frame_bad = 0;
    start = 1'b1; step(); start = 1'b0;
    chk("f1_busy", 32'({busy, in_ready}), 32'b11);
    for (int off = 0; off < 16384; off++) begin
      logic tk;
      tk = (off == 100 || off == 5000);
      push_byte(off, 1'b1, tk, off == 10);
      if (off == 10) chk("start_busy_err", 32'(error), 32'd1);
      if (tk) chk($sformatf("tick_fill_%0d", off), 32'({busy, frame_done, buffer_num}), 32'b100);
      ack_byte();
      if (off == 10) chk("start_busy_err_once", 32'(error), 32'd0);
    end
    chk("f1_bytes", 32'(frame_bad), 32'd0);
    chk("f1_wait_swap", 32'({busy, in_ready, mem_req, buffer_num}), 32'b1000);
    step();
    chk("f1_wait_hold", 32'({busy, buffer_num, frame_done}), 32'b100);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("f1_flip", 32'({buffer_num, frame_done, busy, error}), 32'b1100);
    step();
    chk("f1_done_once", 32'({buffer_num, frame_done}), 32'b10);

    // Frame 2: back buffer 0, flip coincides with a start
    frame_bad = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int off = 0; off < 16384; off++) begin
      push_byte(off, 1'b0, 1'b0, 1'b0);
      ack_byte();
    end
    chk("f2_bytes", 32'(frame_bad), 32'd0);
    frame_tick = 1'b1; start = 1'b1; step(); frame_tick = 1'b0; start = 1'b0;
    chk("f2_flip_start", 32'({buffer_num, frame_done, busy, error}), 32'b0101);
    step();
    chk("f2_after", 32'({buffer_num, frame_done, busy, error}), 32'b0000);

    // Timeout: request never acknowledged
    frame_bad = 0;
    start = 1'b1; step(); start = 1'b0;
    push_byte(0, 1'b1, 1'b0, 1'b0);
    chk("tmo_first_req", 32'(frame_bad), 32'd0);
    cnt = 0;
    while (mem_req && cnt < 400) begin
      cnt++;
      step();
    end
    chk("tmo_req_cycles", 32'(cnt), 32'd255);
    chk("tmo_err", 32'({error, busy, mem_req, buffer_num}), 32'b1000);
    step();
    chk("tmo_err_once", 32'({error, busy}), 32'b00);

    // Reset in the middle of a fill
    start = 1'b1; step(); start = 1'b0;
    push_byte(0, 1'b1, 1'b0, 1'b0);
    chk("rst_pre", 32'({busy, mem_req}), 32'b11);
    rst_n = 1'b0; step();
    chk("rst_mid_fill", 32'(observed()), 32'h0);
    rst_n = 1'b1; step();
    chk("rst_stays_idle", 32'(observed()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/loader_fb_sched.md
Name: loader_fb_sched

Overview:
- Schedules frame uploads into the loader's double-buffered CHR memory.
- Accepts a byte stream from the MCU bridge and writes it, one byte per memory handshake, into the back buffer (the half not shown to the PPU).
- On the CPU's next vblank acknowledge, flips buffer_num so the loader shows the new frame.
- Sits between the MCU bridge, the CHR memory write port and the loader's buffer_num input.

Parameters:
- BUF_BYTES, 16384, bytes per buffer (4 banks x 4 KiB); power of two.
- ADDR_BITS, 15, memory address width = log2(BUF_BYTES)+1.
- TIMEOUT, 255, max cycles mem_req may wait for mem_ack.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse: begin uploading a new frame.
- abort  in  1  one-cycle pulse: cancel the current upload.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- mem_addr  out  ADDR_BITS  write address {back_buf, offset}.
- mem_wdata  out  8  write data.
- mem_req  out  1  write request; held until mem_ack.
- mem_ack  in  1  write completed; one-cycle pulse.
- frame_tick  in  1  one-cycle pulse, already synchronised to clk: CPU acknowledged vblank.
- buffer_num  out  1  front buffer index, drives the loader.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse on buffer flip.
- error  out  1  one-cycle pulse: start while busy, or memory timeout.

Behaviour:
- Reset values: buffer_num=0, in_ready=0, mem_req=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, error=0, offset=0, state=IDLE. Reset mid-upload discards everything; no flip.
- back_buf = ~buffer_num, sampled at start and held for the whole upload.
- IDLE:
  - start -> FILL, offset=0.
  - frame_tick and abort are ignored.
- FILL:
  - in_ready = 1 when mem_req=0 (no skid buffer).
  - in_valid && in_ready: latch mem_wdata=in_data and mem_addr={back_buf, offset}. mem_req=1 from the next cycle.
  - mem_req, mem_addr and mem_wdata stay stable until mem_ack is sampled high. mem_req drops the cycle after mem_ack.
  - Throughput is at most one byte per 2 cycles.
  - On mem_ack: offset+1. If the acked offset == BUF_BYTES-1, go to WAIT_SWAP. offset never wraps inside a frame.
  - A timeout counter resets on each new request and counts while mem_req=1 && !mem_ack. On reaching TIMEOUT: drop mem_req, pulse error, go to IDLE, no flip.
  - mem_ack while mem_req=0 is ignored.
- WAIT_SWAP:
  - in_ready=0.
  - frame_tick: buffer_num toggles and frame_done pulses in the same cycle; go to IDLE.
- abort:
  - In FILL with mem_req=0: go to IDLE immediately.
  - In FILL with mem_req=1: set a pending-abort flag, wait for mem_ack or timeout, then go to IDLE. No error pulse on this path; the write that was in flight still completes.
  - In WAIT_SWAP: go to IDLE immediately, no flip.
  - abort always wins over frame_tick in the same cycle.
- start while busy: ignored, error pulses, the upload in progress is unaffected. Applies also to start coincident with frame_tick in WAIT_SWAP: the flip happens and error pulses.
- frame_tick outside WAIT_SWAP has no effect, so buffer_num only ever changes after a complete frame.
- Latency: last mem_ack -> WAIT_SWAP next cycle; frame_tick -> buffer_num toggled at the following edge.

Test Plan:
- Reset, then start, then 16384 bytes (in_data=offset[7:0]) with mem_ack one cycle after each req -> addresses 0x4000..0x7FFF in order, data matches. frame_tick then gives buffer_num=1 and one frame_done pulse.
- Second full frame with buffer_num=1 -> writes to 0x0000..0x3FFF. frame_tick gives buffer_num=0.
- frame_tick pulses during FILL at offset 100 and 5000 -> buffer_num unchanged, upload continues; the flip happens only on the tick after the last ack.
- abort at offset 300 with mem_req high, mem_ack 3 cycles later -> that write completes, then IDLE; busy=0, buffer_num unchanged, no error.
- start at offset 10 -> one error pulse, offset and addresses continue uninterrupted. start coincident with frame_tick in WAIT_SWAP -> buffer_num flips, error pulses, state IDLE.
- mem_ack withheld with TIMEOUT=255 -> mem_req drops after 255 cycles, error pulses once, busy=0. Reset asserted mid-FILL -> all outputs return to reset values the next cycle.
